// File: rtl/seq_pattern_detector_pkg.sv
// Shared constants and the compile-time KMP helper for the serial
// pattern detector (state width, mode encodings, next-state function).
package seq_pattern_detector_pkg;

  localparam bit MODE_MEALY = 1'b0;
  localparam bit MODE_MOORE = 1'b1;
  localparam bit OVR_OFF    = 1'b0;
  localparam bit OVR_ON     = 1'b1;
  localparam int MAX_LEN    = 16;
  localparam int ST_W       = 4;

  // Longest k <= kmax such that the first k pattern bits equal the
  // last k bits of (prefix(s) followed by b). Only ever evaluated
  // in localparam context, so the loops never reach hardware.
  // Bit i of the prefix (i=0 received first) is pat[len-1-i].
  function automatic logic [ST_W-1:0] kmp_next(
    input logic [MAX_LEN-1:0] pat,
    input int                 len,
    input int                 s,
    input logic               b,
    input int                 kmax
  );
    int   best;
    int   idx;
    logic ok;
    logic sb;
    best = 0;
    for (int k = kmax; k >= 1; k--) begin
      ok = 1'b1;
      for (int j = 0; j < k; j++) begin
        idx = s + 1 - k + j;
        sb  = (idx == s) ? b : pat[len-1-idx];
        if (sb != pat[len-1-j]) ok = 1'b0;
      end
      if (ok && best == 0) best = k;
    end
    return best[ST_W-1:0];
  endfunction

endpackage

// File: rtl/seq_fallback_table.sv
// Combinational next-state lookup for the pattern detector.
// Ports: state/x in; nstate (KMP successor), hit (final bit matched) out.
module seq_fallback_table
  import seq_pattern_detector_pkg::*;
#(
  parameter int             LEN     = 4,
  parameter logic [LEN-1:0] PATTERN = 4'b1011
) (
  input  logic [ST_W-1:0] state,
  input  logic            x,
  output logic [ST_W-1:0] nstate,
  output logic            hit
);

  localparam logic [MAX_LEN-1:0] PAT =
    MAX_LEN'(PATTERN);
  localparam logic [ST_W-1:0] LAST =
    ST_W'(LEN - 1);

  logic [ST_W-1:0] ns0 [MAX_LEN];
  logic [ST_W-1:0] ns1 [MAX_LEN];

  // Row s: successor after seeing 0 / 1.
  // In the last row a full match is capped at
  // LEN-1, which yields the overlap border.
  for (genvar s = 0; s < MAX_LEN; s++) begin : g_row
    if (s < LEN) begin : g_live
      localparam int KMAX =
        (s + 1 < LEN) ? s + 1 : LEN - 1;
      localparam logic [ST_W-1:0] N0 =
        kmp_next(PAT, LEN, s, 1'b0, KMAX);
      localparam logic [ST_W-1:0] N1 =
        kmp_next(PAT, LEN, s, 1'b1, KMAX);
      assign ns0[s] = N0;
      assign ns1[s] = N1;
    end else begin : g_pad
      assign ns0[s] = '0;
      assign ns1[s] = '0;
    end
  end

  always_comb begin
    nstate = x ? ns1[state] : ns0[state];
    hit    = (state == LAST) &&
             (x == PATTERN[0]);
  end

endmodule

// File: rtl/seq_pattern_detector.sv
// Serial sequence detector: x sampled when y=1, z flags PATTERN.
// Ports: clk, rst_n, x, y, clear in; z, match_count, state_dbg out.
module seq_pattern_detector
  import seq_pattern_detector_pkg::*;
#(
  parameter int             LEN     = 4,
  parameter logic [LEN-1:0] PATTERN = 4'b1011,
  parameter bit             MOORE   = 1'b0,
  parameter bit             OVERLAP = 1'b1,
  parameter int             CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             x,
  input  logic             y,
  input  logic             clear,
  output logic             z,
  output logic [CNT_W-1:0] match_count,
  output logic [4:0]       state_dbg
);

  if (LEN < 2 || LEN > MAX_LEN || CNT_W < 1)
  begin : g_bad_params
    $error("seq_pattern_detector: bad LEN/CNT_W");
  end

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [ST_W-1:0]  state_q;
  logic [ST_W-1:0]  state_d;
  logic [ST_W-1:0]  nstate;
  logic             hit;
  logic             match_ev;
  logic             z_q;
  logic             z_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  seq_fallback_table #(
    .LEN     (LEN),
    .PATTERN (PATTERN)
  ) u_table (
    .state  (state_q),
    .x      (x),
    .nstate (nstate),
    .hit    (hit)
  );

  // clear suppresses a coincident match
  assign match_ev = y & ~clear & hit;

  always_comb begin
    state_d = state_q;
    z_d     = 1'b0;
    cnt_d   = cnt_q;
    if (clear) begin
      state_d = '0;
      cnt_d   = '0;
    end else if (y) begin
      z_d = match_ev;
      if (match_ev && OVERLAP == OVR_OFF)
        state_d = '0;
      else
        state_d = nstate;
      if (match_ev && cnt_q != CNT_MAX)
        cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= '0;
      z_q     <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      z_q     <= z_d;
      cnt_q   <= cnt_d;
    end
  end

  assign z = (MOORE == MODE_MOORE) ?
             z_q : (match_ev & rst_n);
  assign match_count = cnt_q;
  assign state_dbg   = {1'b0, state_q};

endmodule

// File: tb/tb_seq_pattern_detector.sv
// Directed bench for seq_pattern_detector.
// Four configurations share one input stream.
module tb_seq_pattern_detector;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       x;
  logic       y;
  logic       clear;
  logic       za, zb, zc, zd;
  logic [7:0] ca, cb, cc;
  logic [1:0] cd;
  logic [4:0] sa, sb, sc, sd;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  seq_pattern_detector u_a (
    .clk(clk), .rst_n(rst_n), .x(x), .y(y),
    .clear(clear), .z(za), .match_count(ca),
    .state_dbg(sa)
  );

  seq_pattern_detector #(.OVERLAP(1'b0)) u_b (
    .clk(clk), .rst_n(rst_n), .x(x), .y(y),
    .clear(clear), .z(zb), .match_count(cb),
    .state_dbg(sb)
  );

  seq_pattern_detector #(.MOORE(1'b1)) u_c (
    .clk(clk), .rst_n(rst_n), .x(x), .y(y),
    .clear(clear), .z(zc), .match_count(cc),
    .state_dbg(sc)
  );

  seq_pattern_detector #(
    .PATTERN(4'b1111), .CNT_W(2)
  ) u_d (
    .clk(clk), .rst_n(rst_n), .x(x), .y(y),
    .clear(clear), .z(zd), .match_count(cd),
    .state_dbg(sd)
  );

  task automatic chk(input string tag,
                     input logic [15:0] obs,
                     input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d",
             tag, obs, exp);
    end
  endtask

  // drive just after the edge, return mid-cycle
  task automatic step(input logic xv,
                      input logic yv,
                      input logic cv);
    @(posedge clk);
    #1;
    x = xv;
    y = yv;
    clear = cv;
    #2;
  endtask

  logic [6:0] bits1 = 7'b1011011;
  logic [6:0] za_e  = 7'b0001001;
  logic [6:0] zb_e  = 7'b0001000;
  logic [6:0] zc_e  = 7'b0000100;
  int sa_e [7] = '{0, 1, 2, 3, 1, 2, 3};
  int sb_e [7] = '{0, 1, 2, 3, 0, 0, 1};
  logic [3:0] bits4 = 4'b1011;
  int sa4_e [4] = '{1, 2, 3, 1};

  initial begin
    rst_n = 1'b0;
    x = 1'b0;
    y = 1'b0;
    clear = 1'b0;
    #2;
    chk("rst_sa", 16'(sa), 16'd0);
    chk("rst_za", 16'(za), 16'd0);
    chk("rst_zc", 16'(zc), 16'd0);
    chk("rst_ca", 16'(ca), 16'd0);
    chk("rst_cd", 16'(cd), 16'd0);
    #10;
    rst_n = 1'b1;

    // overlapping / non-overlapping / Moore
    for (int i = 0; i < 7; i++) begin
      step(bits1[6-i], 1'b1, 1'b0);
      chk("t1_za", 16'(za), 16'(za_e[6-i]));
      chk("t2_zb", 16'(zb), 16'(zb_e[6-i]));
      chk("t3_zc", 16'(zc), 16'(zc_e[6-i]));
      chk("t1_sa", 16'(sa), 16'(sa_e[i]));
      chk("t2_sb", 16'(sb), 16'(sb_e[i]));
    end
    step(1'b0, 1'b0, 1'b0);
    chk("t3_zc_last", 16'(zc), 16'd1);
    chk("t1_za_idle", 16'(za), 16'd0);
    chk("t1_sa_end", 16'(sa), 16'd1);
    chk("t1_ca", 16'(ca), 16'd2);
    chk("t2_cb", 16'(cb), 16'd1);
    chk("t3_cc", 16'(cc), 16'd2);
    chk("t1_cd", 16'(cd), 16'd0);
    step(1'b0, 1'b0, 1'b0);
    chk("t3_zc_pulse", 16'(zc), 16'd0);

    // clear, then valid gaps
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0);
    chk("clr_ca", 16'(ca), 16'd0);
    chk("clr_sa", 16'(sa), 16'd0);
    chk("clr_cc", 16'(cc), 16'd0);
    for (int i = 0; i < 4; i++) begin
      step(bits4[3-i], 1'b1, 1'b0);
      chk("t4_za", 16'(za), 16'(i == 3));
      for (int g = 0; g < 2; g++) begin
        step(1'($urandom), 1'b0, 1'b0);
        chk("t4_gap_sa", 16'(sa), 16'(sa4_e[i]));
        chk("t4_gap_za", 16'(za), 16'd0);
        chk("t4_gap_zc", 16'(zc),
            16'(i == 3 && g == 0));
      end
    end
    chk("t4_ca", 16'(ca), 16'd1);

    // saturating counter
    step(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 9; i++) begin
      step(1'b1, 1'b1, 1'b0);
      if (i == 2) chk("t5_zd3", 16'(zd), 16'd0);
      if (i == 3) chk("t5_zd4", 16'(zd), 16'd1);
      if (i == 8) chk("t5_zd9", 16'(zd), 16'd1);
    end
    step(1'b0, 1'b0, 1'b0);
    chk("t5_cd_sat", 16'(cd), 16'd3);
    chk("t5_sd", 16'(sd), 16'd3);
    chk("t5_ca", 16'(ca), 16'd0);
    chk("t5_sa", 16'(sa), 16'd1);

    // clear on the final bit beats the match
    step(1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b1);
    chk("t6c_za", 16'(za), 16'd0);
    chk("t6c_zb", 16'(zb), 16'd0);
    step(1'b0, 1'b0, 1'b0);
    chk("t6c_ca", 16'(ca), 16'd0);
    chk("t6c_sa", 16'(sa), 16'd0);
    chk("t6c_zc", 16'(zc), 16'd0);

    // async reset mid-sequence
    step(1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    chk("t6r_za_pre", 16'(za), 16'd1);
    rst_n = 1'b0;
    #1;
    chk("t6r_za", 16'(za), 16'd0);
    chk("t6r_sa", 16'(sa), 16'd0);
    chk("t6r_zc", 16'(zc), 16'd0);
    #1;
    rst_n = 1'b1;
    step(1'b0, 1'b0, 1'b0);
    chk("t6r_ca", 16'(ca), 16'd0);
    chk("t6r_sa_after", 16'(sa), 16'd1);
    chk("t6r_zc_after", 16'(zc), 16'd0);

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
